hlcp_cmd_seq: RTL and testbench

Register-bus command sequencer that sits directly upstream of the HLCP controller top and drives its `sys_sel`/`sys_rd`/`sys_wr`/`sys_addr`/`sys_wdata` port, sampling `sys_rdata` and `hlcp_int`. It accepts single register commands (write, read, poll-until-match, wait-for-interrupt) over a valid/ready handshake. It executes each command as zero-wait-state bus cycles and returns one response per command, with timeout and abort reporting. This lets a host or microsequencer run HLCP transfers without cycle-level bus handling.

---
 rtl/hlcp_cmd_seq.sv | 133 +++++++++++++
 tb/tb_hlcp_cmd_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hlcp_cmd_seq.sv
// hlcp_cmd_seq: register-bus command sequencer driving the HLCP controller system port
module hlcp_cmd_seq #(
    parameter logic [15:0] TIMEOUT  = 16'd1000,
    parameter logic [3:0]  POLL_GAP = 4'd4
) (
    input  logic        sys_clk,
    input  logic        sys_resetb,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [31:0] cmd_mask,
    input  logic        seq_abort,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_op,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        m_sel,
    output logic        m_rd,
    output logic        m_wr,
    output logic [3:0]  m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        hlcp_int,
    output logic        seq_busy
);
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, CHECK, GAP, WAITI, RESP} state_t;
    localparam logic [1:0] OP_WR = 2'd0, OP_POLL = 2'd2, OP_WAIT = 2'd3;
    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [3:0]  addr_q, addr_d, gap_q, gap_d, m_addr_q;
    logic [31:0] data_q, data_d, mask_q, mask_d, rdata_q, rdata_d, m_wdata_q;
    logic [15:0] timer_q;
    logic        abort_q, err_q, err_d, accept, hit, expired, bus_d;
    logic        cmd_ready_q, rsp_valid_q, m_sel_q, m_rd_q, m_wr_q, busy_q;
    assign accept  = state_q == IDLE && cmd_valid;
    assign hit     = ((rdata_q ^ data_q) & mask_q) == 32'd0;
    assign expired = timer_q >= TIMEOUT;
    assign bus_d   = state_d == SETUP || state_d == ACCESS;
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        gap_d   = gap_q;
        op_d    = accept ? cmd_op : op_q;
        addr_d  = accept ? cmd_addr : addr_q;
        data_d  = accept ? cmd_data : data_q;
        mask_d  = accept ? cmd_mask : mask_q;
        rdata_d = accept ? 32'd0 : (state_q == ACCESS && op_q != OP_WR) ? m_rdata : rdata_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                state_d = cmd_op == OP_WAIT ? WAITI : SETUP;
                err_d   = 1'b0;
            end
            SETUP:  state_d = ACCESS;
            ACCESS: state_d = op_q == OP_POLL ? CHECK : RESP;
            CHECK: begin
                gap_d = 4'd0;
                if (hit) state_d = RESP;
                else if (abort_q || expired) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else state_d = POLL_GAP == 4'd0 ? SETUP : GAP;
            end
            GAP: if (abort_q || seq_abort || expired) begin
                state_d = RESP;
                err_d   = 1'b1;
            end else if (gap_q == POLL_GAP - 4'd1) state_d = SETUP;
            else gap_d = gap_q + 4'd1;
            // interrupt outranks a coincident abort or timeout
            WAITI: if (hlcp_int) state_d = RESP;
            else if (abort_q || seq_abort || expired) begin
                state_d = RESP;
                err_d   = 1'b1;
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge sys_clk or negedge sys_resetb) begin
        if (!sys_resetb) begin
            state_q     <= IDLE;
            op_q        <= 2'd0;
            addr_q      <= 4'd0;
            data_q      <= 32'd0;
            mask_q      <= 32'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            gap_q       <= 4'd0;
            timer_q     <= 16'd0;
            abort_q     <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            m_sel_q     <= 1'b0;
            m_rd_q      <= 1'b0;
            m_wr_q      <= 1'b0;
            m_addr_q    <= 4'd0;
            m_wdata_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            gap_q       <= gap_d;
            timer_q     <= state_q == IDLE ? 16'd0 : timer_q + {15'd0, timer_q != 16'hFFFF};
            abort_q     <= state_q != IDLE && (abort_q || (seq_abort && state_q != RESP));
            cmd_ready_q <= state_d == IDLE;
            rsp_valid_q <= state_d == RESP;
            busy_q      <= state_d != IDLE;
            m_sel_q     <= bus_d;
            m_rd_q      <= state_d == ACCESS;
            m_wr_q      <= bus_d && op_d == OP_WR;
            m_addr_q    <= state_d == SETUP ? addr_d : m_addr_q;
            m_wdata_q   <= state_d == SETUP && op_d == OP_WR ? data_d : m_wdata_q;
        end
    end
    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_op    = op_q;
    assign rsp_data  = rdata_q;
    assign rsp_err   = err_q;
    assign m_sel     = m_sel_q;
    assign m_rd      = m_rd_q;
    assign m_wr      = m_wr_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign seq_busy  = busy_q;
endmodule

// File: tb/tb_hlcp_cmd_seq.sv
// tb_hlcp_cmd_seq: vector table plus hand sequences, responses checked through a scoreboard queue
module tb_hlcp_cmd_seq;
    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;
    typedef struct {
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] mask;
        logic [31:0] rdata;
        logic        intr;
        int          hold;
        logic [31:0] xdata;
        logic        xerr;
        int          xlat;
    } vec_t;
    logic        sys_clk = 1'b0, sys_resetb = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, seq_abort = 1'b0, rsp_ready = 1'b0, hlcp_int = 1'b0;
    logic [1:0]  cmd_op = 2'd0, rsp_op;
    logic [3:0]  cmd_addr = 4'd0, m_addr, acc_addr;
    logic [31:0] cmd_data = 32'd0, cmd_mask = 32'd0, rsp_data, m_wdata, m_rdata, acc_wdata;
    logic        rsp_valid, rsp_err, m_sel, m_rd, m_wr, seq_busy, acc_wr;
    logic        poll_mode = 1'b0, poll_hit = 1'b0;
    logic [31:0] rd_val = 32'd0;
    int          cyc = 0, acc0 = 0, n_cmp = 0, n_bad = 0, nacc = 0, nsetup = 0, poll_base = 0;
    int          acc_log[$];
    exp_t        sb[$];
    vec_t        vt[6];

    hlcp_cmd_seq #(.TIMEOUT(16'd50), .POLL_GAP(4'd4)) dut (
        .sys_clk(sys_clk), .sys_resetb(sys_resetb), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .seq_abort(seq_abort), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .m_sel(m_sel), .m_rd(m_rd), .m_wr(m_wr),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .hlcp_int(hlcp_int), .seq_busy(seq_busy)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // bus slave: poll reads return bit0 set from the third read on when poll_hit is armed
    assign m_rdata = poll_mode ? ((poll_hit && (nacc - poll_base) >= 3) ? 32'd1 : 32'd0) : rd_val;
    always @(negedge sys_clk) begin
        if (m_sel && m_rd) begin
            nacc      <= nacc + 1;
            acc_log.push_back(cyc);
            acc_addr  <= m_addr;
            acc_wdata <= m_wdata;
            acc_wr    <= m_wr;
        end else if (m_sel) nsetup <= nsetup + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] op, input logic [31:0] d, input logic e, input int l);
        exp_t r;
        r.op = op;
        r.data = d;
        r.err = e;
        r.lat = l;
        return r;
    endfunction

    task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [31:0] d, input logic [31:0] m, input exp_t e);
        for (int i = 0; i < 100 && !cmd_ready; i++) begin @(posedge sys_clk); #1; end
        chk("cmd_ready_before_send", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_addr = a;
        cmd_data = d;
        cmd_mask = m;
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
        acc0 = cyc - 1;
        sb.push_back(e);
    endtask

    task automatic get_rsp(input int hold);
        exp_t e;
        for (int i = 0; i < 3000 && !rsp_valid; i++) begin @(posedge sys_clk); #1; end
        e = sb.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_op", 32'(rsp_op), 32'(e.op));
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_latency", 32'(cyc - acc0), 32'(e.lat));
        for (int k = 0; k < hold; k++) begin
            @(posedge sys_clk); #1;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", rsp_data, e.data);
            chk("hold_err", 32'(rsp_err), 32'(e.err));
        end
        rsp_ready = 1'b1;
        @(posedge sys_clk); #1;
        rsp_ready = 1'b0;
        chk("ready_after_rsp", 32'(cmd_ready), 32'd1);
    endtask

    task automatic pulse(input int at, input logic ab, input logic in);
        for (int i = 0; i < 200 && cyc - acc0 < at; i++) begin @(posedge sys_clk); #1; end
        seq_abort = ab;
        hlcp_int = in;
        @(posedge sys_clk); #1;
        seq_abort = 1'b0;
        hlcp_int = 1'b0;
    endtask

    initial begin
        int s0, a0, b0, bexp;
        vt[0] = '{2'd0, 4'h3, 32'hA5A5_0001, 32'h0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 3};
        vt[1] = '{2'd1, 4'h5, 32'h0, 32'h0, 32'h0000_00C3, 1'b0, 4, 32'h0000_00C3, 1'b0, 3};
        vt[2] = '{2'd0, 4'hF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 3};
        vt[3] = '{2'd1, 4'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 3};
        vt[4] = '{2'd2, 4'h2, 32'h10, 32'hF0, 32'h1234_5615, 1'b0, 0, 32'h1234_5615, 1'b0, 4};
        vt[5] = '{2'd3, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 0, 32'h0, 1'b0, 2};
        #1 sys_resetb = 1'b0;
        #1;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_bus", 32'({m_sel, m_rd, m_wr}), 32'd0);
        chk("reset_busy", 32'(seq_busy), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk) sys_resetb = 1'b1;
        @(posedge sys_clk); #1;

        for (int v = 0; v < 6; v++) begin
            rd_val = vt[v].rdata;
            hlcp_int = vt[v].intr;
            s0 = nsetup;
            a0 = nacc;
            bexp = vt[v].op == 2'd3 ? 0 : 1;
            send(vt[v].op, vt[v].addr, vt[v].data, vt[v].mask, mk(vt[v].op, vt[v].xdata, vt[v].xerr, vt[v].xlat));
            get_rsp(vt[v].hold);
            hlcp_int = 1'b0;
            chk("setup_cycles", 32'(nsetup - s0), 32'(bexp));
            chk("access_cycles", 32'(nacc - a0), 32'(bexp));
            if (bexp == 1) begin
                chk("access_addr", 32'(acc_addr), 32'(vt[v].addr));
                chk("access_wr", 32'(acc_wr), 32'(vt[v].op == 2'd0));
            end
            if (vt[v].op == 2'd0) chk("access_wdata", acc_wdata, vt[v].data);
        end

        // reset during ACCESS must drop strobes immediately and swallow the response
        rd_val = 32'h55;
        cmd_op = 2'd1;
        cmd_addr = 4'h7;
        cmd_valid = 1'b1;
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
        @(posedge sys_clk); #1;
        chk("rst_pre_access", 32'({m_sel, m_rd}), 32'd3);
        sys_resetb = 1'b0;
        #1;
        chk("rst_strobes", 32'({m_sel, m_rd, m_wr}), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(seq_busy), 32'd0);
        @(negedge sys_clk) sys_resetb = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge sys_clk); #1;
            chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
            chk("rst_ready", 32'(cmd_ready), 32'd1);
        end

        send(2'd0, 4'h9, 32'h1234_5678, 32'h0, mk(2'd0, 32'h0, 1'b0, 3));
        pulse(1, 1'b1, 1'b0);
        get_rsp(0);

        poll_mode = 1'b1;
        poll_hit = 1'b1;
        poll_base = nacc;
        b0 = acc_log.size();
        send(2'd2, 4'h1, 32'h1, 32'h1, mk(2'd2, 32'h1, 1'b0, 18));
        get_rsp(0);
        chk("poll_reads", 32'(nacc - poll_base), 32'd3);
        chk("poll_space1", 32'(acc_log[b0 + 1] - acc_log[b0]), 32'd7);
        chk("poll_space2", 32'(acc_log[b0 + 2] - acc_log[b0 + 1]), 32'd7);

        poll_hit = 1'b0;
        poll_base = nacc;
        send(2'd2, 4'h1, 32'h1, 32'h1, mk(2'd2, 32'h0, 1'b1, 53));
        get_rsp(0);
        chk("poll_to_reads", 32'(nacc - poll_base), 32'd8);
        repeat (5) @(posedge sys_clk);
        #1;
        chk("poll_to_quiet", 32'(nacc - poll_base), 32'd8);

        poll_base = nacc;
        send(2'd2, 4'h1, 32'h1, 32'h1, mk(2'd2, 32'h0, 1'b1, 6));
        pulse(5, 1'b1, 1'b0);
        get_rsp(0);
        chk("poll_abort_reads", 32'(nacc - poll_base), 32'd1);
        poll_mode = 1'b0;

        send(2'd3, 4'h0, 32'h0, 32'h0, mk(2'd3, 32'h0, 1'b0, 21));
        pulse(20, 1'b0, 1'b1);
        get_rsp(0);
        send(2'd3, 4'h0, 32'h0, 32'h0, mk(2'd3, 32'h0, 1'b1, 11));
        pulse(10, 1'b1, 1'b0);
        get_rsp(0);
        send(2'd3, 4'h0, 32'h0, 32'h0, mk(2'd3, 32'h0, 1'b0, 11));
        pulse(10, 1'b1, 1'b1);
        get_rsp(0);
        send(2'd3, 4'h0, 32'h0, 32'h0, mk(2'd3, 32'h0, 1'b1, 52));
        get_rsp(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
